// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline sequencing controller and the pipeline stages.
//
// Hazard / debug requests (pipeline -> controller):
//   load_use_stall  load-use hazard detected in decode
//   branch_taken    EX redirect valid this cycle
//   ex_busy         multi-cycle EX unit has not finished
//   dmem_wait       data memory not ready; whole pipe must freeze
//   halt_req        debug halt request (level)
//   resume_req      debug resume request (level)
// Stage controls / status (controller -> pipeline):
//   pc_we, pc_redirect                 PC update and branch-target select
//   if_id_we/flush, id_ex_we/flush     front pipeline register load / bubble
//   ex_mem_we/flush, mem_wb_we         back pipeline register load / bubble
//   halted                             controller is parked in HALTED
//   cycle_cnt, stall_cnt, flush_cnt    performance counters (CNT_W bits)
//
// Modport master is the controller side, slave is the pipeline side.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_use_stall;
  logic             branch_taken;
  logic             ex_busy;
  logic             dmem_wait;
  logic             halt_req;
  logic             resume_req;

  logic             pc_we;
  logic             pc_redirect;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             ex_mem_flush;
  logic             mem_wb_we;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  load_use_stall,
    input  branch_taken,
    input  ex_busy,
    input  dmem_wait,
    input  halt_req,
    input  resume_req,
    output pc_we,
    output pc_redirect,
    output if_id_we,
    output if_id_flush,
    output id_ex_we,
    output id_ex_flush,
    output ex_mem_we,
    output ex_mem_flush,
    output mem_wb_we,
    output halted,
    output cycle_cnt,
    output stall_cnt,
    output flush_cnt
  );

  modport slave (
    output load_use_stall,
    output branch_taken,
    output ex_busy,
    output dmem_wait,
    output halt_req,
    output resume_req,
    input  pc_we,
    input  pc_redirect,
    input  if_id_we,
    input  if_id_flush,
    input  id_ex_we,
    input  id_ex_flush,
    input  ex_mem_we,
    input  ex_mem_flush,
    input  mem_wb_we,
    input  halted,
    input  cycle_cnt,
    input  stall_cnt,
    input  flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central sequencing controller for the 5-stage pipeline. Merges the load-use
// stall, EX branch redirect, multi-cycle EX busy and data-memory wait into the
// per-stage write-enable / flush strobes, runs the debug halt/resume FSM
// (RUN -> DRAIN -> HALTED -> RUN) and keeps cycle/stall/flush counters.
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    pipe_ctrl_if.master (hazard/debug inputs, stage strobes, status)
//
// Strobes are combinational from the registered state and the current hazard
// inputs; state, drain counter, halted flag and perf counters are registered.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned CNT_W         = 32,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.master bus
);

  // Drain counter must hold DRAIN_CYCLES; keep at least one bit.
  localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0]    DRAIN_ZERO = DW'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam state_t RESET_STATE = HALT_ON_RESET ? ST_HALTED : ST_RUN;

  state_t           state_r;
  state_t           state_s;
  logic [DW-1:0]    drain_cnt_r;
  logic [DW-1:0]    drain_cnt_s;
  logic             halted_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic in_run_s;
  logic in_drain_s;
  logic active_s;
  logic hazard_s;
  logic stall_evt_s;
  logic flush_evt_s;

  logic pc_we_s;
  logic pc_redirect_s;
  logic if_id_we_s;
  logic if_id_flush_s;
  logic id_ex_we_s;
  logic id_ex_flush_s;
  logic ex_mem_we_s;
  logic ex_mem_flush_s;
  logic mem_wb_we_s;

  // State decode into one-hot style qualifiers used by strobes and counters.
  always_comb begin
    in_run_s   = 1'b0;
    in_drain_s = 1'b0;
    case (state_r)
      ST_RUN:    in_run_s   = 1'b1;
      ST_DRAIN:  in_drain_s = 1'b1;
      ST_HALTED: in_run_s   = 1'b0;
      default:   in_run_s   = 1'b0;
    endcase
  end

  assign active_s = in_run_s | in_drain_s;

  // A branch wins over ex_busy/load_use but never over dmem_wait, so a stall
  // is counted whenever the memory freezes or a lower hazard is not overridden.
  assign hazard_s    = bus.ex_busy | bus.load_use_stall;
  assign stall_evt_s = active_s & (bus.dmem_wait | (~bus.branch_taken & hazard_s));
  assign flush_evt_s = active_s & ~bus.dmem_wait & bus.branch_taken;

  // Next-state and drain-counter logic for the halt/resume FSM.
  always_comb begin
    state_s     = state_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (bus.halt_req) begin
          state_s     = ST_DRAIN;
          drain_cnt_s = DRAIN_LOAD;
        end else begin
          state_s     = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus.dmem_wait) begin
          drain_cnt_s = drain_cnt_r;
        end else if (bus.branch_taken) begin
          // Redirect refills the front with bubbles behind it: restart drain.
          drain_cnt_s = DRAIN_LOAD;
        end else if (hazard_s) begin
          drain_cnt_s = drain_cnt_r;
        end else if (drain_cnt_r <= DRAIN_ONE) begin
          // This unfrozen cycle retires the last in-flight instruction.
          drain_cnt_s = DRAIN_ZERO;
          state_s     = ST_HALTED;
        end else begin
          drain_cnt_s = drain_cnt_r - DRAIN_ONE;
        end
      end
      ST_HALTED: begin
        // resume_req has priority; halt_req is meaningless here.
        if (bus.resume_req) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s     = RESET_STATE;
        drain_cnt_s = DRAIN_ZERO;
      end
    endcase
  end

  // Per-stage strobe generation in priority order.
  always_comb begin
    pc_we_s        = 1'b0;
    pc_redirect_s  = 1'b0;
    if_id_we_s     = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_we_s     = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_we_s    = 1'b0;
    ex_mem_flush_s = 1'b0;
    mem_wb_we_s    = 1'b0;
    if (reset) begin
      pc_we_s = 1'b0;
    end else if (!active_s) begin
      pc_we_s = 1'b0;
    end else if (bus.dmem_wait) begin
      // Whole pipe frozen.
      pc_we_s = 1'b0;
    end else if (bus.branch_taken) begin
      // Also taken in DRAIN so a later resume fetches the branch target.
      pc_we_s       = 1'b1;
      pc_redirect_s = 1'b1;
      if_id_we_s    = 1'b1;
      if_id_flush_s = 1'b1;
      id_ex_we_s    = 1'b1;
      id_ex_flush_s = 1'b1;
      ex_mem_we_s   = 1'b1;
      mem_wb_we_s   = 1'b1;
    end else if (bus.ex_busy) begin
      // Front holds, a bubble enters MEM, WB keeps retiring.
      ex_mem_we_s    = 1'b1;
      ex_mem_flush_s = 1'b1;
      mem_wb_we_s    = 1'b1;
    end else if (bus.load_use_stall) begin
      // IF/ID held without flush so the stalled ID instruction survives DRAIN.
      id_ex_we_s    = 1'b1;
      id_ex_flush_s = 1'b1;
      ex_mem_we_s   = 1'b1;
      mem_wb_we_s   = 1'b1;
    end else if (in_drain_s) begin
      // Fetch stopped: feed bubbles into ID while the rest drains.
      if_id_we_s    = 1'b1;
      if_id_flush_s = 1'b1;
      id_ex_we_s    = 1'b1;
      ex_mem_we_s   = 1'b1;
      mem_wb_we_s   = 1'b1;
    end else begin
      pc_we_s     = 1'b1;
      if_id_we_s  = 1'b1;
      id_ex_we_s  = 1'b1;
      ex_mem_we_s = 1'b1;
      mem_wb_we_s = 1'b1;
    end
  end

  // FSM state, drain counter and halted flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RESET_STATE;
      drain_cnt_r <= DRAIN_ZERO;
      halted_r    <= HALT_ON_RESET;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
      halted_r    <= (state_s == ST_HALTED);
    end
  end

  // Performance counters; they wrap naturally and hold while HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_r <= CNT_ZERO;
      stall_cnt_r <= CNT_ZERO;
      flush_cnt_r <= CNT_ZERO;
    end else begin
      if (active_s) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (stall_evt_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.pc_we        = pc_we_s;
  assign bus.pc_redirect  = pc_redirect_s;
  assign bus.if_id_we     = if_id_we_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_we     = id_ex_we_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_we    = ex_mem_we_s;
  assign bus.ex_mem_flush = ex_mem_flush_s;
  assign bus.mem_wb_we    = mem_wb_we_s;
  assign bus.halted       = halted_r;
  assign bus.cycle_cnt    = cycle_cnt_r;
  assign bus.stall_cnt    = stall_cnt_r;
  assign bus.flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. A behavioural model describes each cycle
// as a per-stage action (hold / load / bubble, PC next / target) and tracks
// mode, remaining drain work and counter totals with plain integers.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int DRAIN = 4;
  localparam int CW    = 32;
  localparam bit HOR   = 1'b0;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  typedef enum int {A_HOLD, A_LOAD, A_BUBBLE, A_NEXT, A_TARGET} act_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(
    .DRAIN_CYCLES (DRAIN),
    .CNT_W        (CW),
    .HALT_ON_RESET(HOR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          m_mode  = M_RUN;
  int          m_left  = 0;
  int unsigned m_cyc   = 0;
  int unsigned m_stl   = 0;
  int unsigned m_fl    = 0;
  bit          m_known = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobes {pc_we,pc_redirect,if_id_we,if_id_flush,id_ex_we,
  // id_ex_flush,ex_mem_we,ex_mem_flush,mem_wb_we} from per-stage actions.
  function automatic logic [8:0] model_strobes(input bit rst, lu, br, eb, dw);
    act_t pc, s1, s2, s3, s4;
    if (rst || m_mode == M_HALT || dw) begin
      pc = A_HOLD; s1 = A_HOLD; s2 = A_HOLD; s3 = A_HOLD; s4 = A_HOLD;
    end else if (br) begin
      pc = A_TARGET; s1 = A_BUBBLE; s2 = A_BUBBLE; s3 = A_LOAD; s4 = A_LOAD;
    end else if (eb) begin
      pc = A_HOLD; s1 = A_HOLD; s2 = A_HOLD; s3 = A_BUBBLE; s4 = A_LOAD;
    end else if (lu) begin
      pc = A_HOLD; s1 = A_HOLD; s2 = A_BUBBLE; s3 = A_LOAD; s4 = A_LOAD;
    end else if (m_mode == M_DRAIN) begin
      pc = A_HOLD; s1 = A_BUBBLE; s2 = A_LOAD; s3 = A_LOAD; s4 = A_LOAD;
    end else begin
      pc = A_NEXT; s1 = A_LOAD; s2 = A_LOAD; s3 = A_LOAD; s4 = A_LOAD;
    end
    return {pc != A_HOLD, pc == A_TARGET,
            s1 != A_HOLD, s1 == A_BUBBLE,
            s2 != A_HOLD, s2 == A_BUBBLE,
            s3 != A_HOLD, s3 == A_BUBBLE,
            s4 != A_HOLD};
  endfunction

  task automatic model_update(input bit rst, lu, br, eb, dw, hr, rr);
    if (rst) begin
      m_mode  = HOR ? M_HALT : M_RUN;
      m_left  = 0;
      m_cyc   = 0;
      m_stl   = 0;
      m_fl    = 0;
      m_known = 1'b1;
    end else if (m_mode == M_HALT) begin
      if (rr) m_mode = M_RUN;
    end else begin
      m_cyc++;
      if (dw || (!br && (eb || lu))) m_stl++;
      if (!dw && br) m_fl++;
      if (m_mode == M_RUN) begin
        if (hr) begin
          m_mode = M_DRAIN;
          m_left = DRAIN;
        end
      end else if (!dw) begin
        if (br) m_left = DRAIN;
        else if (!(eb || lu)) begin
          m_left--;
          if (m_left == 0) m_mode = M_HALT;
        end
      end
    end
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic cyc(input bit rst, lu, br, eb, dw, hr, rr);
    logic [8:0] got_s;
    reset              = rst;
    bus.load_use_stall = lu;
    bus.branch_taken   = br;
    bus.ex_busy        = eb;
    bus.dmem_wait      = dw;
    bus.halt_req       = hr;
    bus.resume_req     = rr;
    @(negedge clk);
    got_s = {bus.pc_we, bus.pc_redirect, bus.if_id_we, bus.if_id_flush,
             bus.id_ex_we, bus.id_ex_flush, bus.ex_mem_we, bus.ex_mem_flush,
             bus.mem_wb_we};
    check_eq("strobes", got_s, model_strobes(rst, lu, br, eb, dw));
    if (m_known) begin
      check_eq("halted", bus.halted, m_mode == M_HALT);
      check_eq("cycle_cnt", bus.cycle_cnt, m_cyc);
      check_eq("stall_cnt", bus.stall_cnt, m_stl);
      check_eq("flush_cnt", bus.flush_cnt, m_fl);
    end
    @(posedge clk);
    model_update(rst, lu, br, eb, dw, hr, rr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lat;
    reset              = 1'b1;
    bus.load_use_stall = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.ex_busy        = 1'b0;
    bus.dmem_wait      = 1'b0;
    bus.halt_req       = 1'b0;
    bus.resume_req     = 1'b0;
    #1;

    // Reset then 10 idle cycles.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    check_eq("idle_cycle_cnt", bus.cycle_cnt, 64'd10);
    check_eq("idle_stall_cnt", bus.stall_cnt, 64'd0);
    check_eq("idle_halted", bus.halted, 1'b0);

    // Single load-use stall.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_eq("lu_stall_cnt", bus.stall_cnt, 64'd1);

    // Branch together with load-use: branch wins.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("br_flush_cnt", bus.flush_cnt, 64'd1);
    check_eq("br_stall_cnt", bus.stall_cnt, 64'd1);

    // dmem_wait 3 cycles during ex_busy, then 2 ex_busy-only cycles.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_eq("dw_eb_stall_cnt", bus.stall_cnt, 64'd6);

    // Halt pulse, two dmem_wait cycles inside DRAIN.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lat = 1;
    while (!bus.halted && lat < 30) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, (lat == 2 || lat == 4), 1'b0, 1'b0);
      lat++;
    end
    check_eq("halt_latency", lat, DRAIN + 2 + 1);
    // Inputs ignored while halted, including halt_req.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
          $urandom_range(1), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("resume_halted", bus.halted, 1'b0);
    idle(1);

    // Branch in second DRAIN cycle reloads the drain.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    lat = 0;
    while (!bus.halted && lat < 30) begin
      idle(1);
      lat++;
    end
    check_eq("branch_drain_latency", lat, DRAIN);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a drain.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_eq("mid_drain_reset_cycle_cnt", bus.cycle_cnt, 64'd2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(199) == 0),
          ($urandom_range(4) == 0),
          ($urandom_range(9) == 0),
          ($urandom_range(6) == 0),
          ($urandom_range(9) == 0),
          ($urandom_range(19) == 0),
          ($urandom_range(4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
